ram_be_clr: RTL and testbench
=============================

// Module: ram_be_clr
// PURPOSE
//  Single-port synchronous RAM, next generation of the team's small register-file RAM.
//  Adds exact power-of-two depth, per-lane write enables, registered read with valid
//  strobe, selectable read-during-write mode and a hardware zero-fill sweep after reset.
//  Used as scratch/config storage behind tile I/O; busy gates all accesses during clear.
// PARAMETERS
//  ADDR_WIDTH  4  address bits; DEPTH = 2**ADDR_WIDTH words, exactly (no spare word)
//  DATA_WIDTH  8  word width in bits
//  LANE_WIDTH  4  write-enable lane width; DATA_WIDTH % LANE_WIDTH == 0; LANES = DATA_WIDTH/LANE_WIDTH
//  RDW_MODE    0  same-address read+write in one cycle: 0 = old data, 1 = new (merged) data
// PORTS
//  clk       in   1           clock, all state on rising edge
//  rst       in   1           synchronous active-high reset
//  we        in   1           write request, sampled at posedge
//  re        in   1           read request, sampled at posedge
//  addr      in   ADDR_WIDTH  word address for read and/or write
//  be        in   LANES       lane enables; lane i = data_in[i*LANE_WIDTH +: LANE_WIDTH]
//  data_in   in   DATA_WIDTH  write data
//  data_out  out  DATA_WIDTH  registered read data, held until next accepted read
//  rd_valid  out  1           one-cycle pulse: data_out updated this cycle
//  busy      out  1           high during reset and zero-fill sweep; requests ignored
// BEHAVIOUR
//  - Reset (rst=1 at posedge): data_out=0, rd_valid=0, busy=1, state=CLEAR, sweep ptr=0.
//    Memory contents are not touched while rst is held.
//  - FSM: CLEAR -> IDLE. CLEAR: each cycle write 0 to mem[ptr], ptr++; after writing
//    word DEPTH-1 go IDLE, busy=0 next cycle. Sweep takes exactly DEPTH cycles after rst
//    deasserts; busy falls on the edge after the last write.
//  - rst asserted mid-sweep restarts sweep from ptr=0. rst in IDLE re-clears whole RAM.
//  - busy=1: we/re ignored (no write, no rd_valid); no queuing, caller must retry.
//  - IDLE write: we=1 -> for each lane i with be[i]=1, mem[addr] lane i <= data_in lane i;
//    be=0 with we=1 is a legal no-op. Writes visible to reads issued next cycle onward.
//  - IDLE read: re=1 at edge N -> data_out = mem[addr] and rd_valid=1 after edge N
//    (latency 1). rd_valid drops after edge N+1 unless re=1 again; back-to-back reads
//    every cycle sustained. data_out holds last value when no read accepted.
//  - re=we=1 same cycle (same addr): RDW_MODE=0 returns pre-write word; RDW_MODE=1
//    returns word with enabled lanes replaced by data_in, untouched lanes old.
//  - addr is always in range (full 2**ADDR_WIDTH decode); no wrap or out-of-range case.
//  - No combinational path from inputs to outputs.
// TESTING (defaults: DEPTH=16, DATA=8, LANES=2 unless stated)
//  1 rst 1 cycle, then count busy cycles -> busy high exactly 16 cycles; read all 16
//    addresses -> each data_out=0x00 with rd_valid one cycle after re.
//  2 Preload addr 5 = 0xA5 (be=2'b11); write 0x3C be=2'b01 -> read addr 5 = 0xAC;
//    write 0xFF be=2'b00 -> read still 0xAC.
//  3 RDW: addr 7 = 0x12, then we=re=1 addr 7 data 0x9E be=2'b10: RDW_MODE=0 -> 0x12,
//    RDW_MODE=1 -> 0x92; following read -> 0x92 in both builds.
//  4 Fill addr 0..15 with 0x10+addr, assert rst at sweep cycle 6, hold 2 cycles ->
//    busy 16 more cycles after release; all words read 0x00.
//  5 During busy issue we=1 addr 3 data 0x55 and re=1 -> no rd_valid; after sweep
//    read addr 3 = 0x00.
//  6 Back-to-back reads addr 1,2,3 on consecutive cycles (values 0x11,0x22,0x33) ->
//    rd_valid high 3 cycles, data_out 0x11,0x22,0x33, then rd_valid=0 and data_out holds 0x33.

Source files
------------

// File: rtl/ram_be_clr.sv
// ram_be_clr: single-port synchronous RAM with per-lane write enables,
// a registered read with a valid strobe, a selectable read-during-write
// mode, and a hardware zero-fill sweep after every reset.
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-high reset
//   we        in   write request
//   re        in   read request
//   addr      in   word address for read and/or write
//   be        in   lane enables, lane i = data_in[i*LANE_WIDTH +: LANE_WIDTH]
//   data_in   in   write data
//   data_out  out  registered read data, held until the next accepted read
//   rd_valid  out  one-cycle pulse, data_out updated this cycle
//   busy      out  high during reset and the zero-fill sweep; requests ignored
module ram_be_clr #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned RDW_MODE   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               we,
    input  logic                               re,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   be,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               rd_valid,
    output logic                               busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    busy_q, busy_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;

    // Stored word with enabled lanes replaced by write data.
    always_comb begin
        old_word    = mem[addr];
        merged_word = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                merged_word[i*LANE_WIDTH +: LANE_WIDTH] = data_in[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Next-state, memory write port and read register logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        rd_valid_d = 1'b0;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = merged_word;

        case (state_q)
            CLEAR: begin
                // Sweep owns the write port; user requests are dropped.
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + ADDR_WIDTH'(1);
                busy_d    = 1'b1;
                if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                busy_d = 1'b0;
                mem_we = we;
                if (re) begin
                    rd_valid_d = 1'b1;
                    // Same-cycle write can only target the same address (shared addr).
                    data_out_d = (we && (RDW_MODE == 1)) ? merged_word : old_word;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage array; left untouched while rst is held.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_be_clr.sv
// Directed bench for ram_be_clr: two instances (old-data and new-data
// read-during-write) share one stimulus stream.
module tb_ram_be_clr;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [1:0] be;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       rv0, rv1;
    logic       busy0, busy1;

    int tests  = 0;
    int failed = 0;
    int n;

    always #5 clk = ~clk;

    ram_be_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .be(be),
        .data_in(data_in), .data_out(dout0), .rd_valid(rv0), .busy(busy0)
    );

    ram_be_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .be(be),
        .data_in(data_in), .data_out(dout1), .rd_valid(rv1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request, sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [3:0] a,
                       input logic [1:0] b, input logic [7:0] d);
        we = w; re = r; addr = a; be = b; data_in = d;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic rd_both(input string tag, input logic [3:0] a,
                           input logic [7:0] e0, input logic [7:0] e1);
        cyc(1'b0, 1'b1, a, 2'b00, 8'h00);
        chk({tag, "_rv0"}, 32'(rv0), 32'd1);
        chk({tag, "_rv1"}, 32'(rv1), 32'd1);
        chk({tag, "_d0"}, 32'(dout0), 32'(e0));
        chk({tag, "_d1"}, 32'(dout1), 32'(e1));
    endtask

    // Count cycles with busy high, bounded.
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy0 && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; be = '0; data_in = '0;

        // Reset state.
        @(posedge clk); #1;
        chk("rst_busy",  32'(busy0), 32'd1);
        chk("rst_rv",    32'(rv0),   32'd0);
        chk("rst_dout",  32'(dout0), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd1);
        rst = 1'b0;

        // 1: sweep length, then every word reads zero.
        wait_busy(n);
        chk("t1_busy_cycles", 32'(n), 32'd16);
        chk("t1_busy1_low", 32'(busy1), 32'd0);
        for (int a = 0; a < 16; a++) rd_both("t1_rd", 4'(a), 8'h00, 8'h00);
        cyc(1'b0, 1'b0, 4'd0, 2'b00, 8'h00);
        chk("t1_rv_drop", 32'(rv0), 32'd0);

        // 2: lane writes.
        cyc(1'b1, 1'b0, 4'd5, 2'b11, 8'hA5);
        cyc(1'b1, 1'b0, 4'd5, 2'b01, 8'h3C);
        rd_both("t2_lane0", 4'd5, 8'hAC, 8'hAC);
        cyc(1'b1, 1'b0, 4'd5, 2'b00, 8'hFF);
        rd_both("t2_be0", 4'd5, 8'hAC, 8'hAC);
        cyc(1'b1, 1'b0, 4'd5, 2'b10, 8'h7E);
        rd_both("t2_lane1", 4'd5, 8'h7C, 8'h7C);

        // 3: read during write.
        cyc(1'b1, 1'b0, 4'd7, 2'b11, 8'h12);
        cyc(1'b1, 1'b1, 4'd7, 2'b10, 8'h9E);
        chk("t3_rdw_rv",  32'(rv0),   32'd1);
        chk("t3_rdw_old", 32'(dout0), 32'h12);
        chk("t3_rdw_new", 32'(dout1), 32'h92);
        rd_both("t3_after", 4'd7, 8'h92, 8'h92);

        // 6: back-to-back reads then hold.
        cyc(1'b1, 1'b0, 4'd1, 2'b11, 8'h11);
        cyc(1'b1, 1'b0, 4'd2, 2'b11, 8'h22);
        cyc(1'b1, 1'b0, 4'd3, 2'b11, 8'h33);
        rd_both("t6_a1", 4'd1, 8'h11, 8'h11);
        rd_both("t6_a2", 4'd2, 8'h22, 8'h22);
        rd_both("t6_a3", 4'd3, 8'h33, 8'h33);
        cyc(1'b0, 1'b0, 4'd9, 2'b00, 8'h00);
        chk("t6_rv_low", 32'(rv0),   32'd0);
        chk("t6_hold0",  32'(dout0), 32'h33);
        chk("t6_hold1",  32'(dout1), 32'h33);

        // 4: fill, reset mid-sweep, full re-clear.
        for (int a = 0; a < 16; a++) cyc(1'b1, 1'b0, 4'(a), 2'b11, 8'(8'h10 + a));
        rd_both("t4_fill", 4'd14, 8'h1E, 8'h1E);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t4_busy_hold", 32'(busy0), 32'd1);
        chk("t4_dout_rst",  32'(dout0), 32'd0);
        rst = 1'b0;
        wait_busy(n);
        chk("t4_busy_cycles", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) rd_both("t4_rd", 4'(a), 8'h00, 8'h00);

        // 5: requests during busy are dropped (issued after the sweep passed addr 3).
        cyc(1'b1, 1'b0, 4'd3, 2'b11, 8'hC3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        cyc(1'b1, 1'b1, 4'd3, 2'b11, 8'h55);
        chk("t5_busy",   32'(busy0), 32'd1);
        chk("t5_no_rv0", 32'(rv0),   32'd0);
        chk("t5_no_rv1", 32'(rv1),   32'd0);
        wait_busy(n);
        chk("t5_busy_left", 32'(n), 32'd7);
        rd_both("t5_rd3", 4'd3, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
